cordic_side_delay: RTL

Parametrised delay line that carries side-channel data (packed quadrant/angle index plus NCH residual words) alongside the CORDIC rotation pipeline, so it arrives at the final stage aligned with the rotated X/Y. It generalises the fixed five-stage, two-channel buffer with configurable depth, width and channel count. It adds per-stage valid tracking, pipeline-wide stall, synchronous flush and an in-flight occupancy count. It sits between the ROM read buffer and the CORDIC output combiner.

---
 rtl/cordic_side_delay.sv | 115 +++++++++++
 1 files changed

// File: rtl/cordic_side_delay.sv
// cordic_side_delay
//
// Delay line that carries side-channel data (packed quadrant/angle index plus
// NCH residual words) alongside the CORDIC rotation pipeline, so that it
// reaches the output combiner aligned with the rotated X/Y. Each of the DEPTH
// stages holds a valid bit, an index and NCH data words. The whole pipe
// advances together under `en`. `flush` clears every valid bit, and an
// occupancy counter tracks how many valid beats are in flight.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (clears all stages)
//   en         advance enable; 0 holds every register (stall)
//   flush      synchronous clear of all valid bits; wins over en
//   in_valid   input beat valid
//   in_idx     index accompanying the input beat
//   in_data    NCH packed channels, channel c at [c*DATA_W +: DATA_W]
//   out_valid  valid bit of the last stage
//   out_idx    index of the last stage
//   out_data   data of the last stage
//   occupancy  number of valid beats held in stages 0..DEPTH-1
//   busy       occupancy != 0 (registered)
module cordic_side_delay #(
  parameter int DEPTH        = 5,
  parameter int IDX_W        = 11,
  parameter int DATA_W       = 16,
  parameter int NCH          = 2,
  parameter int ZERO_INVALID = 0,
  parameter int OCC_W        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic                  out_valid,
  output logic [IDX_W-1:0]      out_idx,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  busy
);

  localparam int W = NCH * DATA_W;
  localparam bit ZERO_EN = (ZERO_INVALID != 0);

  logic [DEPTH-1:0] v_q, v_d;
  logic [IDX_W-1:0] idx_q  [DEPTH];
  logic [IDX_W-1:0] idx_d  [DEPTH];
  logic [W-1:0]     data_q [DEPTH];
  logic [W-1:0]     data_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             busy_q, busy_d;

  // Next-state for the stage registers and occupancy: flush > shift > hold.
  always_comb begin
    v_d    = v_q;
    idx_d  = idx_q;
    data_d = data_q;
    occ_d  = occ_q;
    if (flush) begin
      v_d   = '0;
      occ_d = '0;
      for (int s = 0; s < DEPTH; s++) begin
        // Without zeroing, payloads simply keep their stale contents.
        idx_d[s]  = ZERO_EN ? '0 : idx_q[s];
        data_d[s] = ZERO_EN ? '0 : data_q[s];
      end
    end else if (en) begin
      v_d[0]    = in_valid;
      idx_d[0]  = (ZERO_EN && !in_valid) ? '0 : in_idx;
      data_d[0] = (ZERO_EN && !in_valid) ? '0 : in_data;
      for (int s = 1; s < DEPTH; s++) begin
        v_d[s]    = v_q[s-1];
        idx_d[s]  = (ZERO_EN && !v_q[s-1]) ? '0 : idx_q[s-1];
        data_d[s] = (ZERO_EN && !v_q[s-1]) ? '0 : data_q[s-1];
      end
      // One beat may enter and one leave per edge, so the count stays within 0..DEPTH.
      occ_d = occ_q + OCC_W'(in_valid) - OCC_W'(v_q[DEPTH-1]);
    end else begin
      v_d    = v_q;
      idx_d  = idx_q;
      data_d = data_q;
      occ_d  = occ_q;
    end
    busy_d = (occ_d != '0);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q    <= '0;
      occ_q  <= '0;
      busy_q <= 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
        idx_q[s]  <= '0;
        data_q[s] <= '0;
      end
    end else begin
      v_q    <= v_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      occ_q  <= occ_d;
      busy_q <= busy_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;
  assign busy      = busy_q;

endmodule
